// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and helpers for the instruction-fetch front end.
package fetch_pkg;

   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
   localparam int unsigned CNT_W_DEFAULT    = 32'd16;

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   // Redirect targets are forced onto a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/pc_incrementer.sv
// Sequential next-PC adder: pc + PC_STEP, wrapping modulo 2^32 with no carry out.
module pc_incrementer
   import fetch_pkg::*;
(
   input  logic [31:0] pc,
   output logic [31:0] pc_next
);

   assign pc_next = pc + PC_STEP;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch front end: program counter, IF/ID pipeline register, fetch counter and BOOT/RUN FSM.
module pc_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT,
   parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [31:0]      branch_target,
   input  logic [31:0]      instr_in,
   output logic [31:0]      pc_out,
   output logic [31:0]      ifid_instr,
   output logic [31:0]      ifid_pc4,
   output logic             ifid_valid,
   output logic [CNT_W-1:0] fetch_count
);

   fetch_state_e     state_r;
   fetch_state_e     state_nxt_s;
   logic [31:0]      pc_r;
   logic [31:0]      pc_next_seq_s;
   logic [31:0]      ifid_instr_r;
   logic [31:0]      ifid_pc4_r;
   logic             ifid_valid_r;
   logic [CNT_W-1:0] fetch_count_r;
   logic             load_branch_s;
   logic             load_seq_s;

   pc_incrementer u_pc_incrementer (
      .pc      (pc_r),
      .pc_next (pc_next_seq_s)
   );

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= BOOT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic: BOOT is left on the first edge that either fetches or redirects
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         BOOT: begin
            if (branch_taken || !stall) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = BOOT;
            end
         end
         RUN:     state_nxt_s = RUN;
         default: state_nxt_s = BOOT;
      endcase
   end

   // FSM output decode: branch beats stall, stall beats a sequential fetch
   always_comb begin
      load_branch_s = 1'b0;
      load_seq_s    = 1'b0;
      case (state_r)
         BOOT, RUN: begin
            load_branch_s = branch_taken;
            load_seq_s    = !branch_taken && !stall;
         end
         default: begin
            load_branch_s = 1'b0;
            load_seq_s    = 1'b0;
         end
      endcase
   end

   // Program counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_r <= RESET_PC;
      end else if (load_branch_s) begin
         pc_r <= word_align(branch_target);
      end else if (load_seq_s) begin
         pc_r <= pc_next_seq_s;
      end else begin
         pc_r <= pc_r;
      end
   end

   // IF/ID pipeline register; a redirect squashes the slot
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ifid_instr_r <= NOP_WORD;
         ifid_pc4_r   <= 32'h0000_0000;
         ifid_valid_r <= 1'b0;
      end else if (load_branch_s) begin
         ifid_instr_r <= NOP_WORD;
         ifid_pc4_r   <= 32'h0000_0000;
         ifid_valid_r <= 1'b0;
      end else if (load_seq_s) begin
         ifid_instr_r <= instr_in;
         ifid_pc4_r   <= pc_next_seq_s;
         ifid_valid_r <= 1'b1;
      end else begin
         ifid_instr_r <= ifid_instr_r;
         ifid_pc4_r   <= ifid_pc4_r;
         ifid_valid_r <= ifid_valid_r;
      end
   end

   // Count of real instructions loaded into IF/ID, wrapping at 2^CNT_W
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_count_r <= {CNT_W{1'b0}};
      end else if (load_seq_s) begin
         fetch_count_r <= fetch_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         fetch_count_r <= fetch_count_r;
      end
   end

   assign pc_out      = pc_r;
   assign ifid_instr  = ifid_instr_r;
   assign ifid_pc4    = ifid_pc4_r;
   assign ifid_valid  = ifid_valid_r;
   assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized traffic against a reference model.
module tb_pc_fetch_unit;

   logic        clk           = 1'b0;
   logic        reset_n       = 1'b0;
   logic        stall         = 1'b0;
   logic        branch_taken  = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic [31:0] instr_in      = 32'h0;
   logic [31:0] pc_out;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic [15:0] fetch_count;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pc4;
   logic        m_valid;
   logic [15:0] m_cnt;

   always #5 clk = ~clk;

   pc_fetch_unit dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .instr_in      (instr_in),
      .pc_out        (pc_out),
      .ifid_instr    (ifid_instr),
      .ifid_pc4      (ifid_pc4),
      .ifid_valid    (ifid_valid),
      .fetch_count   (fetch_count)
   );

   task automatic model_reset();
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 16'h0;
   endtask

   // one rising edge of the architectural behaviour
   task automatic model_edge();
      if (branch_taken) begin
         m_pc = {branch_target[31:2], 2'b00};
         m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (!stall) begin
         m_instr = instr_in;
         m_pc4   = m_pc + 32'd4;
         m_pc    = m_pc + 32'd4;
         m_valid = 1'b1;
         m_cnt   = m_cnt + 16'd1;
      end
   endtask

   // advance one clock, sampling 2 time units after the edge
   task automatic edge_step();
      model_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic s, input logic b, input logic [31:0] t, input logic [31:0] i);
      stall = s; branch_taken = b; branch_target = t; instr_in = i;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      n_tests++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc_out, 32'h0); end
      n_tests++; if (ifid_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", ifid_instr, 32'h0); end
      n_tests++; if (ifid_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h expected %h", ifid_pc4, 32'h0); end
      n_tests++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ifid_valid); end
      n_tests++; if (fetch_count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
      reset_n = 1'b1;
   endtask

   task automatic test_sequence();
      logic [31:0] words [3];
      words[0] = 32'hE3A0_0001; words[1] = 32'hE3A0_1002; words[2] = 32'hE080_2001;
      for (int k = 0; k < 3; k++) begin
         n_tests++; if (pc_out !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_pc_pre%0d: got %h expected %h", k, pc_out, 32'(4 * k)); end
         drive(1'b0, 1'b0, 32'h0, words[k]);
         edge_step();
         n_tests++; if (ifid_instr !== words[k]) begin n_fail++; $display("FAIL seq_instr%0d: got %h expected %h", k, ifid_instr, words[k]); end
         n_tests++; if (ifid_pc4 !== 32'(4 * (k + 1))) begin n_fail++; $display("FAIL seq_pc4%0d: got %h expected %h", k, ifid_pc4, 32'(4 * (k + 1))); end
         n_tests++; if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d: got %b expected 1", k, ifid_valid); end
      end
      n_tests++; if (pc_out !== 32'hC) begin n_fail++; $display("FAIL seq_pc_end: got %h expected %h", pc_out, 32'hC); end
      n_tests++; if (fetch_count !== 16'd3) begin n_fail++; $display("FAIL seq_count: got %0d expected 3", fetch_count); end
   endtask

   task automatic test_stall();
      logic [31:0] held;
      drive(1'b0, 1'b0, 32'h0, 32'h1111_2222);
      edge_step();
      held = 32'h1111_2222;
      n_tests++; if (pc_out !== 32'h10) begin n_fail++; $display("FAIL stall_setup_pc: got %h expected %h", pc_out, 32'h10); end
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 1'b0, 32'h0, 32'hDEAD_0000 + 32'(k));
         edge_step();
         n_tests++; if (pc_out !== 32'h10) begin n_fail++; $display("FAIL stall_pc%0d: got %h expected %h", k, pc_out, 32'h10); end
         n_tests++; if (ifid_instr !== held) begin n_fail++; $display("FAIL stall_instr%0d: got %h expected %h", k, ifid_instr, held); end
         n_tests++; if (ifid_pc4 !== 32'h10) begin n_fail++; $display("FAIL stall_pc4%0d: got %h expected %h", k, ifid_pc4, 32'h10); end
         n_tests++; if (fetch_count !== 16'd4) begin n_fail++; $display("FAIL stall_count%0d: got %0d expected 4", k, fetch_count); end
      end
      drive(1'b0, 1'b0, 32'h0, 32'h3333_4444);
      edge_step();
      n_tests++; if (pc_out !== 32'h14) begin n_fail++; $display("FAIL stall_release_pc: got %h expected %h", pc_out, 32'h14); end
      n_tests++; if (ifid_instr !== 32'h3333_4444) begin n_fail++; $display("FAIL stall_release_instr: got %h expected %h", ifid_instr, 32'h3333_4444); end
   endtask

   task automatic test_branch();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 32'h0, 32'h5000_0000 + 32'(k));
         edge_step();
      end
      n_tests++; if (pc_out !== 32'h20) begin n_fail++; $display("FAIL br_setup_pc: got %h expected %h", pc_out, 32'h20); end
      drive(1'b0, 1'b1, 32'h0000_0103, 32'hAAAA_AAAA);
      edge_step();
      n_tests++; if (pc_out !== 32'h100) begin n_fail++; $display("FAIL br_pc: got %h expected %h", pc_out, 32'h100); end
      n_tests++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid: got %b expected 0", ifid_valid); end
      n_tests++; if (ifid_instr !== 32'h0) begin n_fail++; $display("FAIL br_instr: got %h expected %h", ifid_instr, 32'h0); end
      n_tests++; if (ifid_pc4 !== 32'h0) begin n_fail++; $display("FAIL br_pc4: got %h expected %h", ifid_pc4, 32'h0); end
      n_tests++; if (fetch_count !== m_cnt) begin n_fail++; $display("FAIL br_count: got %0d expected %0d", fetch_count, m_cnt); end
      drive(1'b0, 1'b0, 32'h0, 32'hBBBB_0100);
      edge_step();
      n_tests++; if (ifid_pc4 !== 32'h104) begin n_fail++; $display("FAIL br_next_pc4: got %h expected %h", ifid_pc4, 32'h104); end
      n_tests++; if (ifid_instr !== 32'hBBBB_0100) begin n_fail++; $display("FAIL br_next_instr: got %h expected %h", ifid_instr, 32'hBBBB_0100); end
      n_tests++; if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL br_next_valid: got %b expected 1", ifid_valid); end
   endtask

   task automatic test_stall_branch();
      logic [15:0] cnt_before;
      cnt_before = fetch_count;
      drive(1'b1, 1'b1, 32'h0000_0040, 32'hCCCC_CCCC);
      edge_step();
      n_tests++; if (pc_out !== 32'h40) begin n_fail++; $display("FAIL sb_pc: got %h expected %h", pc_out, 32'h40); end
      n_tests++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL sb_valid: got %b expected 0", ifid_valid); end
      n_tests++; if (fetch_count !== cnt_before) begin n_fail++; $display("FAIL sb_count: got %0d expected %0d", fetch_count, cnt_before); end
   endtask

   task automatic test_back_to_back();
      drive(1'b0, 1'b1, 32'h0000_0080, 32'h1);
      edge_step();
      drive(1'b0, 1'b1, 32'h0000_0092, 32'h2);
      edge_step();
      n_tests++; if (pc_out !== 32'h90) begin n_fail++; $display("FAIL b2b_pc: got %h expected %h", pc_out, 32'h90); end
      n_tests++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid: got %b expected 0", ifid_valid); end
   endtask

   task automatic test_wrap();
      drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
      edge_step();
      n_tests++; if (pc_out !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc_top: got %h expected %h", pc_out, 32'hFFFF_FFFC); end
      drive(1'b0, 1'b0, 32'h0, 32'h7777_7777);
      edge_step();
      n_tests++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h expected %h", pc_out, 32'h0); end
      n_tests++; if (ifid_pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %h expected %h", ifid_pc4, 32'h0); end
      n_tests++; if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid: got %b expected 1", ifid_valid); end
   endtask

   task automatic test_async_reset();
      drive(1'b0, 1'b1, 32'h0000_01FC, 32'h0);
      edge_step();
      drive(1'b0, 1'b0, 32'h0, 32'h9999_0001);
      edge_step();
      n_tests++; if (pc_out !== 32'h200 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL ar_setup: got pc %h valid %b expected pc %h valid 1", pc_out, ifid_valid, 32'h200); end
      #1;
      reset_n = 1'b0;
      model_reset();
      #1;
      n_tests++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL ar_pc: got %h expected %h", pc_out, 32'h0); end
      n_tests++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b expected 0", ifid_valid); end
      n_tests++; if (ifid_instr !== 32'h0) begin n_fail++; $display("FAIL ar_instr: got %h expected %h", ifid_instr, 32'h0); end
      n_tests++; if (fetch_count !== 16'h0) begin n_fail++; $display("FAIL ar_count: got %0d expected 0", fetch_count); end
      @(negedge clk);
      reset_n = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 32'h1234_5678);
      #3;
      edge_step();
      n_tests++; if (pc_out !== 32'h4) begin n_fail++; $display("FAIL ar_first_pc: got %h expected %h", pc_out, 32'h4); end
      n_tests++; if (ifid_pc4 !== 32'h4) begin n_fail++; $display("FAIL ar_first_pc4: got %h expected %h", ifid_pc4, 32'h4); end
      n_tests++; if (ifid_instr !== 32'h1234_5678) begin n_fail++; $display("FAIL ar_first_instr: got %h expected %h", ifid_instr, 32'h1234_5678); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), $urandom(), $urandom());
         edge_step();
         n_tests++;
         if (pc_out !== m_pc || ifid_instr !== m_instr || ifid_pc4 !== m_pc4 ||
             ifid_valid !== m_valid || fetch_count !== m_cnt) begin
            n_fail++;
            $display("FAIL rand%0d: got pc %h instr %h pc4 %h v %b cnt %0d expected pc %h instr %h pc4 %h v %b cnt %0d",
                     k, pc_out, ifid_instr, ifid_pc4, ifid_valid, fetch_count,
                     m_pc, m_instr, m_pc4, m_valid, m_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_stall();
      test_branch();
      test_stall_branch();
      test_back_to_back();
      test_wrap();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
